mmc1_bank_ctrl: RTL and testbench

//  Mapper-1 (MMC1) bank controller for the NES cart. Decodes CPU writes to $8000-$FFFF

---
 rtl/mmc1_bank_ctrl.sv | 133 +++++++++++++
 tb/tb_mmc1_bank_ctrl.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/mmc1_bank_ctrl.sv
// MMC1 (mapper 1) bank controller: serial load port, bank registers, PRG/CHR address mapping.
// Optional feature macro: MMC1_SUROM_EN (512K SUROM outer PRG bank taken from CHR bit 4).
module mmc1_bank_ctrl #(
  parameter int unsigned PRG_AW = 19,
  parameter int unsigned CHR_AW = 17
) (
  input  logic              clk_cpu,
  input  logic              rst,
  input  logic              cart_init,
  input  logic [14:0]       cpu_addr,
  input  logic [7:0]        cpu_data_i,
  input  logic              cpu_rw,
  input  logic              romsel,
  input  logic              wram_sel,
  input  logic [13:0]       ppu_addr,
  input  logic [PRG_AW-1:0] prg_mask,
  input  logic [CHR_AW-1:0] chr_mask,
  output logic [PRG_AW-1:0] prg_addr,
  output logic [CHR_AW-1:0] chr_addr,
  output logic              ciram_a10,
  output logic              prgram_en
);

  logic [4:0]  r_ctrl, r_chr0, r_chr1, r_prg, r_shift;
  logic [2:0]  r_cnt;
  logic        r_wr_prev;

  logic [4:0]  w_ctrl_nxt, w_chr0_nxt, w_chr1_nxt, w_prg_nxt, w_shift_nxt, w_val;
  logic [2:0]  w_cnt_nxt;
  logic        w_rom_wr, w_wr_ok;
  logic [3:0]  w_prg_bank;
  logic        w_prg_hi;
  logic [18:0] w_prg_full;
  logic [4:0]  w_chr_bank, w_chr_bank_eff;
  logic [16:0] w_chr_full;
  logic        w_unused;

  // RMW dummy writes land on consecutive cycles; only the first one of a run counts.
  assign w_rom_wr = romsel & ~cpu_rw;
  assign w_wr_ok  = w_rom_wr & ~cart_init & ~r_wr_prev;
  assign w_val    = {cpu_data_i[0], r_shift[4:1]};

  always_comb begin
    w_shift_nxt = r_shift;
    w_cnt_nxt   = r_cnt;
    w_ctrl_nxt  = r_ctrl;
    w_chr0_nxt  = r_chr0;
    w_chr1_nxt  = r_chr1;
    w_prg_nxt   = r_prg;
    if (w_wr_ok) begin
      if (cpu_data_i[7]) begin
        w_shift_nxt = 5'h00;
        w_cnt_nxt   = 3'd0;
        w_ctrl_nxt  = r_ctrl | 5'h0C;
      end else if (r_cnt != 3'd4) begin
        w_shift_nxt = w_val;
        w_cnt_nxt   = r_cnt + 3'd1;
      end else begin
        w_shift_nxt = 5'h00;
        w_cnt_nxt   = 3'd0;
        unique case (cpu_addr[14:13])
          2'd0: w_ctrl_nxt = w_val;
          2'd1: w_chr0_nxt = w_val;
          2'd2: w_chr1_nxt = w_val;
          2'd3: w_prg_nxt  = w_val;
        endcase
      end
    end
  end

  always_ff @(posedge clk_cpu or posedge rst) begin
    if (rst) begin
      r_ctrl    <= 5'h0C;
      r_chr0    <= 5'h00;
      r_chr1    <= 5'h00;
      r_prg     <= 5'h00;
      r_shift   <= 5'h00;
      r_cnt     <= 3'd0;
      r_wr_prev <= 1'b0;
    end else begin
      r_ctrl    <= w_ctrl_nxt;
      r_chr0    <= w_chr0_nxt;
      r_chr1    <= w_chr1_nxt;
      r_prg     <= w_prg_nxt;
      r_shift   <= w_shift_nxt;
      r_cnt     <= w_cnt_nxt;
      r_wr_prev <= w_rom_wr;
    end
  end

  always_comb begin
    w_prg_bank = 4'h0;
    unique case (r_ctrl[3:2])
      2'd0, 2'd1: w_prg_bank = {r_prg[3:1], cpu_addr[14]};
      2'd2:       w_prg_bank = cpu_addr[14] ? r_prg[3:0] : 4'h0;
      2'd3:       w_prg_bank = cpu_addr[14] ? 4'hF : r_prg[3:0];
    endcase
  end

  always_comb begin
    w_chr_bank = 5'h00;
    if (!r_ctrl[4]) w_chr_bank = {r_chr0[4:1], ppu_addr[12]};
    else            w_chr_bank = ppu_addr[12] ? r_chr1 : r_chr0;
  end

`ifdef MMC1_SUROM_EN
  // Outer 256K PRG half follows whichever CHR register is active for the current PPU half.
  assign w_prg_hi       = (r_ctrl[4] & ppu_addr[12]) ? r_chr1[4] : r_chr0[4];
  assign w_chr_bank_eff = {1'b0, w_chr_bank[3:0]};
  assign w_unused       = ^{ppu_addr[13], cpu_data_i[6:1], w_chr_bank[4]};
`else
  assign w_prg_hi       = 1'b0;
  assign w_chr_bank_eff = w_chr_bank;
  assign w_unused       = ^{ppu_addr[13], cpu_data_i[6:1]};
`endif

  assign w_prg_full = {w_prg_hi, w_prg_bank, cpu_addr[13:0]};
  assign w_chr_full = {w_chr_bank_eff, ppu_addr[11:0]};
  assign prg_addr   = PRG_AW'(w_prg_full) & prg_mask;
  assign chr_addr   = CHR_AW'(w_chr_full) & chr_mask;
  assign prgram_en  = wram_sel & ~r_prg[4];

  always_comb begin
    ciram_a10 = 1'b0;
    unique case (r_ctrl[1:0])
      2'd0: ciram_a10 = 1'b0;
      2'd1: ciram_a10 = 1'b1;
      2'd2: ciram_a10 = ppu_addr[10];
      2'd3: ciram_a10 = ppu_addr[11];
    endcase
  end

endmodule

// File: tb/tb_mmc1_bank_ctrl.sv
// Directed self-checking bench for mmc1_bank_ctrl; inputs change 1 ns after each rising edge.
module tb_mmc1_bank_ctrl;

  logic        clk_cpu = 1'b0;
  logic        rst = 1'b1;
  logic        cart_init = 1'b0;
  logic [14:0] cpu_addr = '0;
  logic [7:0]  cpu_data_i = '0;
  logic        cpu_rw = 1'b1;
  logic        romsel = 1'b0;
  logic        wram_sel = 1'b1;
  logic [13:0] ppu_addr = '0;
  logic [18:0] prg_mask = 19'h3FFFF;
  logic [16:0] chr_mask = 17'h1FFFF;
  logic [18:0] prg_addr;
  logic [16:0] chr_addr;
  logic        ciram_a10;
  logic        prgram_en;

  int n_tests = 0;
  int n_fail  = 0;

  localparam logic [14:0] ACtrl = 15'h0000;
  localparam logic [14:0] AChr0 = 15'h2000;
  localparam logic [14:0] AChr1 = 15'h4000;
  localparam logic [14:0] APrg  = 15'h6000;

  mmc1_bank_ctrl #(.PRG_AW(19), .CHR_AW(17)) dut (
    .clk_cpu   (clk_cpu),
    .rst       (rst),
    .cart_init (cart_init),
    .cpu_addr  (cpu_addr),
    .cpu_data_i(cpu_data_i),
    .cpu_rw    (cpu_rw),
    .romsel    (romsel),
    .wram_sel  (wram_sel),
    .ppu_addr  (ppu_addr),
    .prg_mask  (prg_mask),
    .chr_mask  (chr_mask),
    .prg_addr  (prg_addr),
    .chr_addr  (chr_addr),
    .ciram_a10 (ciram_a10),
    .prgram_en (prgram_en)
  );

  always #5 clk_cpu = ~clk_cpu;

  task automatic step();
    @(posedge clk_cpu);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One write cycle followed by one idle cycle so the next write is not back-to-back.
  task automatic wr(input logic [14:0] a, input logic [7:0] d);
    romsel = 1'b1; cpu_rw = 1'b0; cpu_addr = a; cpu_data_i = d;
    step();
    romsel = 1'b0; cpu_rw = 1'b1;
    step();
  endtask

  task automatic load(input logic [14:0] a, input logic [4:0] v);
    for (int i = 0; i < 5; i++) wr(a, {7'b0, v[i]});
  endtask

  task automatic rd_prg(input string tag, input logic [14:0] a, input logic [18:0] exp);
    romsel = 1'b1; cpu_rw = 1'b1; cpu_addr = a;
    #2;
    chk(tag, {13'b0, prg_addr}, {13'b0, exp});
    romsel = 1'b0;
  endtask

  task automatic ck_chr(input string tag, input logic [13:0] p, input logic [16:0] exp);
    ppu_addr = p;
    #2;
    chk(tag, {15'b0, chr_addr}, {15'b0, exp});
  endtask

  task automatic ck_mir(input string tag, input logic [13:0] p, input logic exp);
    ppu_addr = p;
    #2;
    chk(tag, {31'b0, ciram_a10}, {31'b0, exp});
  endtask

  initial begin
    step();
    step();
    rst = 1'b0;
    step();

    // Reset state
    rd_prg("rst_c000", 15'h4000, 19'h3C000);
    rd_prg("rst_8000", 15'h0000, 19'h00000);
    ck_mir("rst_mirror", 14'h2C00, 1'b0);
    chk("rst_prgram_en", {31'b0, prgram_en}, 32'd1);
    ck_chr("rst_chr", 14'h1ABC, 17'h01ABC);
    prg_mask = 19'h1FFFF;
    rd_prg("mask_wrap", 15'h4000, 19'h1C000);
    prg_mask = 19'h3FFFF;

    // PRG register load, mode 3
    load(APrg, 5'h05);
    rd_prg("prg5_8123", 15'h0123, 19'h14123);
    chk("prgram_en_on", {31'b0, prgram_en}, 32'd1);
    wram_sel = 1'b0;
    #1;
    chk("prgram_en_nosel", {31'b0, prgram_en}, 32'd0);
    wram_sel = 1'b1;

    // Mirroring and PRG mode 0
    load(ACtrl, 5'h02);
    ck_mir("mir_v_2400", 14'h2400, 1'b1);
    ck_mir("mir_v_2800", 14'h2800, 1'b0);
    rd_prg("mode0_c000", 15'h4000, 19'h14000);
    rd_prg("mode0_8000", 15'h0000, 19'h10000);
    load(ACtrl, 5'h03);
    ck_mir("mir_h_2800", 14'h2800, 1'b1);
    ck_mir("mir_h_2400", 14'h2400, 1'b0);
    load(ACtrl, 5'h01);
    ck_mir("mir_one_hi", 14'h2000, 1'b1);

    // Partial sequence aborted by D7=1, then mode 2
    wr(ACtrl, 8'h01);
    wr(ACtrl, 8'h01);
    wr(ACtrl, 8'h01);
    wr(ACtrl, 8'h80);
    rd_prg("d7_mode3", 15'h4000, 19'h3C000);
    ck_mir("d7_keeps_mir", 14'h2000, 1'b1);
    load(ACtrl, 5'h08);
    rd_prg("mode2_8000", 15'h0000, 19'h00000);
    rd_prg("mode2_c000", 15'h4000, 19'h14000);
    load(ACtrl, 5'h10);
    rd_prg("ctrl10_c000", 15'h4000, 19'h14000);
    load(AChr1, 5'h03);
    ck_chr("chr1_1abc", 14'h1ABC, 17'h03ABC);
    ck_chr("chr0_0abc", 14'h0ABC, 17'h00ABC);

    // Back-to-back writes: only the first one shifts
    romsel = 1'b1; cpu_rw = 1'b0; cpu_addr = APrg; cpu_data_i = 8'h01;
    step();
    cpu_data_i = 8'h80;
    step();
    cpu_data_i = 8'h00;
    step();
    romsel = 1'b0; cpu_rw = 1'b1;
    step();
    wr(APrg, 8'h01);
    wr(APrg, 8'h01);
    wr(APrg, 8'h00);
    wr(APrg, 8'h00);
    rd_prg("b2b_prg7", 15'h0000, 19'h18000);

    // cart_init freezes the sequence; wr_prev still tracks the frozen write
    wr(APrg, 8'h00);
    wr(APrg, 8'h01);
    cart_init = 1'b1;
    wr(APrg, 8'h01);
    romsel = 1'b1; cpu_rw = 1'b0; cpu_data_i = 8'h01;
    step();
    cart_init = 1'b0;
    step();
    romsel = 1'b0; cpu_rw = 1'b1;
    step();
    rd_prg("init_no_load", 15'h0000, 19'h18000);
    wr(APrg, 8'h00);
    wr(APrg, 8'h01);
    wr(APrg, 8'h00);
    rd_prg("init_resume", 15'h0000, 19'h28000);

    load(APrg, 5'h15);
    chk("prg4_wram_off", {31'b0, prgram_en}, 32'd0);

    // Asynchronous reset mid-sequence
    wr(ACtrl, 8'h01);
    wr(ACtrl, 8'h00);
    #2 rst = 1'b1;
    #1;
    rd_prg("arst_c000", 15'h4000, 19'h3C000);
    rd_prg("arst_8000", 15'h0000, 19'h00000);
    step();
    rst = 1'b0;
    step();
    load(APrg, 5'h03);
    rd_prg("post_rst_load", 15'h0000, 19'h0C000);

    prg_mask = 19'h7FFFF;
    load(AChr0, 5'h10);
`ifdef MMC1_SUROM_EN
    rd_prg("surom_c000", 15'h4000, 19'h7C000);
    ck_chr("surom_chr", 14'h0ABC, 17'h00ABC);
`else
    rd_prg("nosurom_c000", 15'h4000, 19'h3C000);
    ck_chr("nosurom_chr", 14'h0ABC, 17'h10ABC);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
